// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, ALU op classes and the control bundle
// produced by the control unit and carried through the ID/EX register.
package cpu_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [2:0] ALU_OP_ADD    = 3'b000;
  localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;
  localparam logic [2:0] ALU_OP_ILOGIC = 3'b011;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
  } ctrl_t;

  // rt is read as a source by R-type, branch compare and store data.
  function automatic logic uses_rt(input ctrl_t c);
    return c.reg_dst | c.branch | c.mem_write;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction in ID; zero latency, the stall itself is the backpressure to IF/ID.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  ctrl_t      id_ctrl,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       stall
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = uses_rt(id_ctrl) & (ex_rt == id_rt);

  // A load into $0 never produces a value worth waiting for.
  assign stall = ex_valid & ex_mem_read & id_valid & (ex_rt != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall and bubble insertion; 1-cycle latency.
// Flush beats hold beats stall; hold freezes contents, stall loads a bubble.
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [5:0]       id_opcode_i,
  input  logic [5:0]       id_funct_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_reg_dst_i,
  input  logic             id_alu_src_i,
  input  logic             id_mem_to_reg_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             id_mem_write_i,
  input  logic             id_branch_i,
  input  logic             id_jump_i,
  input  logic [2:0]       id_alu_op_i,
  input  logic [DW-1:0]    id_pc4_i,
  input  logic [DW-1:0]    id_rs_data_i,
  input  logic [DW-1:0]    id_rt_data_i,
  input  logic [DW-1:0]    id_imm_i,
  output logic             ex_valid_o,
  output logic [5:0]       ex_opcode_o,
  output logic [5:0]       ex_funct_o,
  output logic [4:0]       ex_rs_o,
  output logic [4:0]       ex_rt_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_reg_dst_o,
  output logic             ex_alu_src_o,
  output logic             ex_mem_to_reg_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             ex_branch_o,
  output logic             ex_jump_o,
  output logic [2:0]       ex_alu_op_o,
  output logic [DW-1:0]    ex_pc4_o,
  output logic [DW-1:0]    ex_rs_data_o,
  output logic [DW-1:0]    ex_rt_data_o,
  output logic [DW-1:0]    ex_imm_o,
  output logic             load_use_stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_t            id_ctrl;
  ctrl_t            ex_ctrl;
  logic             ex_valid;
  logic [5:0]       ex_opcode;
  logic [5:0]       ex_funct;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic [DW-1:0]    ex_pc4;
  logic [DW-1:0]    ex_rs_data;
  logic [DW-1:0]    ex_rt_data;
  logic [DW-1:0]    ex_imm;
  logic [CNT_W-1:0] bubble_cnt;
  logic             stall;
  logic             load_bubble;

  assign id_ctrl = '{reg_dst:    id_reg_dst_i,
                     alu_src:    id_alu_src_i,
                     mem_to_reg: id_mem_to_reg_i,
                     reg_write:  id_reg_write_i,
                     mem_read:   id_mem_read_i,
                     mem_write:  id_mem_write_i,
                     branch:     id_branch_i,
                     jump:       id_jump_i,
                     alu_op:     id_alu_op_i};

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid_i),
    .id_ctrl     (id_ctrl),
    .id_rs       (id_rs_i),
    .id_rt       (id_rt_i),
    .stall       (stall)
  );

  // A held stall keeps its bubble pending rather than inserting it.
  assign load_bubble = flush_i | (~hold_i & stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_opcode  <= '0;
      ex_funct   <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      bubble_cnt <= '0;
    end else if (load_bubble) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_opcode  <= '0;
      ex_funct   <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      if (bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!hold_i) begin
      ex_valid   <= id_valid_i;
      ex_ctrl    <= id_ctrl;
      ex_opcode  <= id_opcode_i;
      ex_funct   <= id_funct_i;
      ex_rs      <= id_rs_i;
      ex_rt      <= id_rt_i;
      ex_rd      <= id_rd_i;
      ex_pc4     <= id_pc4_i;
      ex_rs_data <= id_rs_data_i;
      ex_rt_data <= id_rt_data_i;
      ex_imm     <= id_imm_i;
    end
  end

  assign ex_valid_o       = ex_valid;
  assign ex_opcode_o      = ex_opcode;
  assign ex_funct_o       = ex_funct;
  assign ex_rs_o          = ex_rs;
  assign ex_rt_o          = ex_rt;
  assign ex_rd_o          = ex_rd;
  assign ex_reg_dst_o     = ex_ctrl.reg_dst;
  assign ex_alu_src_o     = ex_ctrl.alu_src;
  assign ex_mem_to_reg_o  = ex_ctrl.mem_to_reg;
  assign ex_reg_write_o   = ex_ctrl.reg_write;
  assign ex_mem_read_o    = ex_ctrl.mem_read;
  assign ex_mem_write_o   = ex_ctrl.mem_write;
  assign ex_branch_o      = ex_ctrl.branch;
  assign ex_jump_o        = ex_ctrl.jump;
  assign ex_alu_op_o      = ex_ctrl.alu_op;
  assign ex_pc4_o         = ex_pc4;
  assign ex_rs_data_o     = ex_rs_data;
  assign ex_rt_data_o     = ex_rt_data;
  assign ex_imm_o         = ex_imm;
  assign load_use_stall_o = stall;
  assign bubble_cnt_o     = bubble_cnt;

endmodule
